// File: rtl/dp_pkg.sv
// Shared types and constants for the dot-product MAC engine.
package dp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } dp_state_e;

    localparam int DP_DATA_W = 8;
    localparam int DP_ACC_W  = 32;
    localparam int DP_LEN_W  = 32;

    // Full-precision width of an unsigned DATA_W x DATA_W product.
    function automatic int prod_width(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/dp_mac_unit.sv
// Combinational multiply-accumulate step with carry detection.
// Build option DP_MAC_SATURATE_EN clamps the sum to all-ones on carry-out instead of wrapping.
module dp_mac_unit
    import dp_pkg::*;
#(
    parameter int DATA_W = DP_DATA_W,
    parameter int ACC_W  = DP_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  next_acc,
    output logic              carry
);

    localparam int PROD_W = prod_width(DATA_W);

    logic [PROD_W-1:0] prod;
    logic [ACC_W:0]    sum;

    always_comb begin
        prod  = PROD_W'(a) * PROD_W'(b);
        // One extra bit catches the carry-out of the accumulate.
        sum   = {1'b0, acc} + (ACC_W + 1)'(prod);
        carry = sum[ACC_W];
`ifdef DP_MAC_SATURATE_EN
        next_acc = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        next_acc = sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/dp_mac_engine.sv
// Dot-product engine: accumulates A[i]*B[i] over vec_len pairs and offers the sum on a valid/ready port.
// Build option DP_MAC_SATURATE_EN (in dp_mac_unit) selects clamping instead of wrap on overflow.
module dp_mac_engine
    import dp_pkg::*;
#(
    parameter int DATA_W = DP_DATA_W,
    parameter int ACC_W  = DP_ACC_W,
    parameter int LEN_W  = DP_LEN_W
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              busy,
    output logic              overflow
);

    dp_state_e          state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   mac_next;
    logic               mac_carry;

    dp_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .acc      (acc_q),
        .a        (in_a),
        .b        (in_b),
        .next_acc (mac_next),
        .carry    (mac_carry)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = vec_len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (vec_len == '0) ? RESULT : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = mac_next;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (mac_carry) begin
                        ovf_d = 1'b1;
                    end
                    // len_q is never zero here, so len_q-1 cannot underflow.
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        res_d   = mac_next;
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign res_valid = (state_q == RESULT);
    assign busy      = (state_q != IDLE);
    assign res_data  = res_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_dp_mac_engine.sv
// Directed-vector bench for dp_mac_engine: a default 32-bit instance plus a 16-bit one for overflow cases.
module tb_dp_mac_engine;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        start = 1'b0;
    logic [31:0] vec_len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        res_ready = 1'b0;

    logic        in_ready, res_valid, busy, overflow;
    logic [31:0] res_data;
    logic        in_ready16, res_valid16, busy16, overflow16;
    logic [15:0] res_data16;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    dp_mac_engine u_dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .start     (start),
        .vec_len   (vec_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .overflow  (overflow)
    );

    dp_mac_engine #(.ACC_W(16)) u_dut16 (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .start     (start),
        .vec_len   (vec_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .in_a      (in_a),
        .in_b      (in_b),
        .res_valid (res_valid16),
        .res_ready (res_ready),
        .res_data  (res_data16),
        .busy      (busy16),
        .overflow  (overflow16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(negedge ACLK);
    endtask

    task automatic start_job(input logic [31:0] len);
        start   = 1'b1;
        vec_len = len;
        cycle();
        start   = 1'b0;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        cycle();
        in_valid = 1'b0;
        in_a     = 8'hAA;
        in_b     = 8'h55;
    endtask

    initial begin
        // Reset values
        cycle();
        cycle();
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data",  64'(res_data),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        ARESETN = 1'b1;
        cycle();

        // Basic job: (1,4),(2,5),(3,6) -> 32
        res_ready = 1'b1;
        start_job(32'd3);
        check("basic_busy", 64'(busy), 64'd1);
        check("basic_in_ready", 64'(in_ready), 64'd1);
        beat(8'd1, 8'd4);
        beat(8'd2, 8'd5);
        beat(8'd3, 8'd6);
        check("basic_res_valid", 64'(res_valid), 64'd1);
        check("basic_res_data", 64'(res_data), 64'h20);
        check("basic_overflow", 64'(overflow), 64'd0);
        check("basic_in_ready_result", 64'(in_ready), 64'd0);
        $display("job len=3 result=0x%0h overflow=%0d", res_data, overflow);
        cycle();
        check("basic_busy_after", 64'(busy), 64'd0);
        check("basic_res_valid_after", 64'(res_valid), 64'd0);

        // Zero length, started the cycle after the previous handshake
        start_job(32'd0);
        check("zero_res_valid", 64'(res_valid), 64'd1);
        check("zero_res_data", 64'(res_data), 64'd0);
        check("zero_in_ready", 64'(in_ready), 64'd0);
        $display("job len=0 result=0x%0h", res_data);
        cycle();
        check("zero_res_valid_after", 64'(res_valid), 64'd0);
        check("zero_in_ready_after", 64'(in_ready), 64'd0);

        // Stalls (in_valid 1,0,0,1,0,1) and 5 cycles of backpressure
        res_ready = 1'b0;
        start_job(32'd3);
        beat(8'd1, 8'd4);
        cycle();
        cycle();
        beat(8'd2, 8'd5);
        cycle();
        beat(8'd3, 8'd6);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_res_valid_%0d", i), 64'(res_valid), 64'd1);
            check($sformatf("bp_res_data_%0d", i), 64'(res_data), 64'h20);
            check($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
            cycle();
        end
        $display("job len=3 stalled result=0x%0h", res_data);
        res_ready = 1'b1;
        cycle();
        check("bp_res_valid_after", 64'(res_valid), 64'd0);

        // Overflow: (255,255) x2 -> 0x1FC02 full width; 16-bit wraps or clamps
        start_job(32'd2);
        beat(8'd255, 8'd255);
        beat(8'd255, 8'd255);
        check("ovf32_res_data", 64'(res_data), 64'h1FC02);
        check("ovf32_overflow", 64'(overflow), 64'd0);
        check("ovf16_res_valid", 64'(res_valid16), 64'd1);
`ifdef DP_MAC_SATURATE_EN
        check("ovf16_res_data", 64'(res_data16), 64'hFFFF);
`else
        check("ovf16_res_data", 64'(res_data16), 64'hFC02);
`endif
        check("ovf16_overflow", 64'(overflow16), 64'd1);
        $display("job len=2 acc16 result=0x%0h overflow=%0d", res_data16, overflow16);
        cycle();

        // start during ACCUM is ignored
        start_job(32'd3);
        beat(8'd1, 8'd4);
        start   = 1'b1;
        vec_len = 32'd5;
        cycle();
        start   = 1'b0;
        beat(8'd2, 8'd5);
        beat(8'd3, 8'd6);
        check("midstart_res_valid", 64'(res_valid), 64'd1);
        check("midstart_res_data", 64'(res_data), 64'h20);
        $display("job len=3 with mid-job start result=0x%0h", res_data);
        cycle();

        // Maximum length does not finish early; reset after the 2nd beat aborts
        start_job(32'hFFFF_FFFF);
        beat(8'd1, 8'd1);
        beat(8'd2, 8'd2);
        check("maxlen_res_valid", 64'(res_valid), 64'd0);
        check("maxlen_busy", 64'(busy), 64'd1);
        ARESETN = 1'b0;
        #1;
        check("abort_in_ready",  64'(in_ready),  64'd0);
        check("abort_res_valid", 64'(res_valid), 64'd0);
        check("abort_res_data",  64'(res_data),  64'd0);
        check("abort_busy",      64'(busy),      64'd0);
        check("abort_overflow",  64'(overflow),  64'd0);
        cycle();
        ARESETN = 1'b1;
        cycle();
        check("abort_no_result", 64'(res_valid), 64'd0);

        // New job after reset: (7,9) -> 63
        start_job(32'd1);
        beat(8'd7, 8'd9);
        check("post_rst_res_valid", 64'(res_valid), 64'd1);
        check("post_rst_res_data", 64'(res_data), 64'h3F);
        $display("job len=1 result=0x%0h", res_data);
        cycle();
        check("post_rst_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
